// File: rtl/alu_issuer.sv
// alu_issuer: queues ALU requests, drives an external combinational ALU, returns results in order.
// Optional feature macro ALU_ISSUER_OVF_EN: registers signed ADD/SUB overflow on rsp_ovf.

package alu_issuer_pkg;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned FUNCT_W = 6;

   localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
   localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
   localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
   localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
   localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

   typedef struct packed {
      logic [DATA_W-1:0]  opa;
      logic [DATA_W-1:0]  opb;
      logic [FUNCT_W-1:0] funct;
   } req_t;
endpackage

module alu_issuer
   import alu_issuer_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [DATA_W-1:0]  req_opA,
   input  logic [DATA_W-1:0]  req_opB,
   input  logic [FUNCT_W-1:0] req_funct,
   output logic [DATA_W-1:0]  alu_dataA,
   output logic [DATA_W-1:0]  alu_dataB,
   output logic [FUNCT_W-1:0] alu_Signal,
   input  logic [DATA_W-1:0]  alu_dataOut,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [DATA_W-1:0]  rsp_data,
   output logic               rsp_err,
   output logic               rsp_ovf,
   output logic               busy
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RESPOND = 2'd2
   } state_t;

   state_t           state, state_d;
   req_t             mem [FIFO_DEPTH];
   req_t             head;
   logic [PTR_W-1:0] wptr, rptr;
   logic [CNT_W-1:0] count;
   logic             push, pop, empty, full;
   logic             head_legal;
   logic             issue, accept;
   logic             cur_err;

   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(FIFO_DEPTH));
   assign req_ready = !full;
   assign push      = req_valid && !full;
   assign head      = mem[rptr];
   assign busy      = (state != IDLE) || !empty;

   always_comb begin
      head_legal = 1'b0;
      case (head.funct)
         FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT: head_legal = 1'b1;
         default:                               head_legal = 1'b0;
      endcase
   end

   // Request storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= {req_opA, req_opB, req_funct};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_W'(1);
         if (pop)  rptr <= rptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d = state;
      pop     = 1'b0;
      issue   = 1'b0;
      accept  = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            issue   = 1'b1;
            state_d = RESPOND;
         end
         RESPOND: begin
            if (rsp_ready) begin
               accept = 1'b1;
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Illegal codes leave the ALU drive untouched and are flagged for the response
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_dataA  <= '0;
         alu_dataB  <= '0;
         alu_Signal <= '0;
         cur_err    <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
      end else begin
         if (pop) begin
            cur_err <= !head_legal;
            if (head_legal) begin
               alu_dataA  <= head.opa;
               alu_dataB  <= head.opb;
               alu_Signal <= head.funct;
            end
         end
         if (issue) begin
            rsp_valid <= 1'b1;
            rsp_err   <= cur_err;
            rsp_data  <= cur_err ? '0 : alu_dataOut;
         end else if (accept) begin
            rsp_valid <= 1'b0;
         end
      end
   end

`ifdef ALU_ISSUER_OVF_EN
   logic ovf_c;

   // Signed overflow judged from the driven operands and the sign of the ALU result
   always_comb begin
      ovf_c = 1'b0;
      if (!cur_err) begin
         case (alu_Signal)
            FN_ADD:  ovf_c = (alu_dataA[DATA_W-1] == alu_dataB[DATA_W-1]) &&
                             (alu_dataOut[DATA_W-1] != alu_dataA[DATA_W-1]);
            FN_SUB:  ovf_c = (alu_dataA[DATA_W-1] != alu_dataB[DATA_W-1]) &&
                             (alu_dataOut[DATA_W-1] != alu_dataA[DATA_W-1]);
            default: ovf_c = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      rsp_ovf <= 1'b0;
      else if (issue) rsp_ovf <= ovf_c;
   end
`else
   assign rsp_ovf = 1'b0;
`endif

endmodule
